// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - arbitrates ROB flush and predictor branch redirects into the fetch PC
// Holds a redirect across I-cache refills, tags fetch with an epoch and drains predictor redirects after flushes.
module fetch_redirect_ctrl #(
   parameter int          EPOCH_W      = 2,
   parameter int          DRAIN_CYCLES = 3,
   parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_flush_en,
   input  logic [31:0]        i_flush_target,
   input  logic               i_branch_en,
   input  logic [31:0]        i_branch_target,
   input  logic               i_refill_busy,
   output logic               o_branch_en,
   output logic               o_flush_en,
   output logic [31:0]        o_redirect_target,
   output logic [EPOCH_W-1:0] o_epoch,
   output logic               o_kill,
   output logic               o_busy
);

   localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

   typedef enum logic {IDLE, PEND} state_t;

   state_t             state_q, state_d;
   logic               pend_flush_q, pend_flush_d;
   logic [31:0]        pend_tgt_q, pend_tgt_d;
   logic               branch_en_q, branch_en_d;
   logic               flush_en_q, flush_en_d;
   logic [31:0]        target_q, target_d;
   logic [EPOCH_W-1:0] epoch_q, epoch_d;
   logic [DW-1:0]      drain_q, drain_d;

   logic               br_acc;
   logic               req_v;
   logic [31:0]        req_tgt;
   logic               eff_flush;
   logic [31:0]        eff_tgt;

   // A pending flush blocks branches so a younger predictor guess cannot replace it.
   assign br_acc  = i_branch_en && (drain_q == '0) && !((state_q == PEND) && pend_flush_q);
   assign req_v   = i_flush_en || br_acc;
   assign req_tgt = i_flush_en ? i_flush_target : i_branch_target;

   assign eff_flush = req_v ? i_flush_en : pend_flush_q;
   assign eff_tgt   = req_v ? req_tgt    : pend_tgt_q;

   always_comb begin
      state_d      = state_q;
      pend_flush_d = pend_flush_q;
      pend_tgt_d   = pend_tgt_q;
      branch_en_d  = 1'b0;
      flush_en_d   = 1'b0;
      target_d     = target_q;
      case (state_q)
         IDLE: begin
            if (req_v) begin
               if (i_refill_busy) begin
                  state_d      = PEND;
                  pend_flush_d = i_flush_en;
                  pend_tgt_d   = req_tgt;
               end else begin
                  flush_en_d  = i_flush_en;
                  branch_en_d = !i_flush_en;
                  target_d    = req_tgt;
               end
            end
         end
         PEND: begin
            if (i_refill_busy) begin
               pend_flush_d = eff_flush;
               pend_tgt_d   = eff_tgt;
            end else begin
               state_d     = IDLE;
               flush_en_d  = eff_flush;
               branch_en_d = !eff_flush;
               target_d    = eff_tgt;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      epoch_d = epoch_q;
      if (flush_en_q || branch_en_q) begin
         epoch_d = epoch_q + EPOCH_W'(1);
      end
      drain_d = drain_q;
      if (flush_en_q) begin
         drain_d = DW'(DRAIN_CYCLES);
      end else if (drain_q != '0) begin
         drain_d = drain_q - DW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         pend_flush_q <= 1'b0;
         pend_tgt_q   <= '0;
         branch_en_q  <= 1'b0;
         flush_en_q   <= 1'b0;
         target_q     <= RESET_VECTOR;
         epoch_q      <= '0;
         drain_q      <= '0;
      end else begin
         state_q      <= state_d;
         pend_flush_q <= pend_flush_d;
         pend_tgt_q   <= pend_tgt_d;
         branch_en_q  <= branch_en_d;
         flush_en_q   <= flush_en_d;
         target_q     <= target_d;
         epoch_q      <= epoch_d;
         drain_q      <= drain_d;
      end
   end

   assign o_branch_en       = branch_en_q;
   assign o_flush_en        = flush_en_q;
   assign o_redirect_target = target_q;
   assign o_epoch           = epoch_q;
   assign o_busy            = (state_q == PEND);
   assign o_kill            = i_flush_en || br_acc || (state_q == PEND) || flush_en_q || branch_en_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - scoreboard bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;

   logic        clk;
   logic        rst_n;
   logic        flush_en;
   logic [31:0] flush_tgt;
   logic        branch_en;
   logic [31:0] branch_tgt;
   logic        refill;
   logic        o_branch_en;
   logic        o_flush_en;
   logic [31:0] o_target;
   logic [1:0]  o_epoch;
   logic        o_kill;
   logic        o_busy;

   typedef struct {
      logic        fl;
      logic [31:0] tgt;
      logic [1:0]  ep;
   } exp_t;

   exp_t       sb[$];
   int         n_total = 0;
   int         n_pass  = 0;
   logic [1:0] exp_ep  = 2'd0;
   logic       chk_ep  = 1'b0;
   logic [1:0] ep_next = 2'd0;

   fetch_redirect_ctrl #(
      .EPOCH_W(2),
      .DRAIN_CYCLES(3),
      .RESET_VECTOR(32'h00000000)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_flush_en(flush_en),
      .i_flush_target(flush_tgt),
      .i_branch_en(branch_en),
      .i_branch_target(branch_tgt),
      .i_refill_busy(refill),
      .o_branch_en(o_branch_en),
      .o_flush_en(o_flush_en),
      .o_redirect_target(o_target),
      .o_epoch(o_epoch),
      .o_kill(o_kill),
      .o_busy(o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push(input logic fl, input logic [31:0] tgt);
      sb.push_back('{fl: fl, tgt: tgt, ep: exp_ep});
      exp_ep = exp_ep + 2'd1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      flush_en  = 1'b0;
      branch_en = 1'b0;
   endtask

   // Monitor: every redirect pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk_ep = 1'b0;
      end else begin
         if (chk_ep) begin
            chk("epoch_inc", {30'd0, o_epoch}, {30'd0, ep_next});
            chk_ep = 1'b0;
         end
         if (o_flush_en || o_branch_en) begin
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_pulse: got flush=%0b branch=%0b target=%0h expected no pulse",
                        o_flush_en, o_branch_en, o_target);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("pulse_kind", {30'd0, o_flush_en, o_branch_en}, e.fl ? 32'd2 : 32'd1);
               chk("pulse_target", o_target, e.tgt);
               chk("pulse_epoch", {30'd0, o_epoch}, {30'd0, e.ep});
               chk_ep  = 1'b1;
               ep_next = e.ep + 2'd1;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; flush_en = 1'b0; flush_tgt = '0;
      branch_en = 1'b0; branch_tgt = '0; refill = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_target", o_target, 32'h0);
      chk("rst_epoch", {30'd0, o_epoch}, 32'd0);
      chk("rst_en", {30'd0, o_flush_en, o_branch_en}, 32'd0);
      rst_n = 1'b1;
      repeat (3) step();

      // Single branch, refill idle
      branch_en = 1'b1; branch_tgt = 32'h100; push(1'b0, 32'h100);
      #1 chk("t1_kill_req", {31'd0, o_kill}, 32'd1);
      step();
      chk("t1_branch_pulse", {31'd0, o_branch_en}, 32'd1);
      chk("t1_kill_pulse", {31'd0, o_kill}, 32'd1);
      step();
      chk("t1_branch_done", {31'd0, o_branch_en}, 32'd0);
      chk("t1_epoch", {30'd0, o_epoch}, 32'd1);
      chk("t1_kill_idle", {31'd0, o_kill}, 32'd0);

      // Flush beats same-cycle branch, then drain window
      flush_en = 1'b1; flush_tgt = 32'h2000;
      branch_en = 1'b1; branch_tgt = 32'h300; push(1'b1, 32'h2000);
      step();
      for (int i = 1; i <= 3; i++) begin
         step();
         branch_en = 1'b1; branch_tgt = 32'h111 * i;
         #1 chk("t2_drain_kill", {31'd0, o_kill}, 32'd0);
      end
      step();
      branch_en = 1'b1; branch_tgt = 32'h444; push(1'b0, 32'h444);
      #1 chk("t2_post_drain_kill", {31'd0, o_kill}, 32'd1);
      step();
      step();
      chk("t2_epoch", {30'd0, o_epoch}, 32'd3);

      // Refill hold: branch pending, overwritten by flush
      refill = 1'b1; branch_en = 1'b1; branch_tgt = 32'h40;
      step();
      chk("t3_busy1", {31'd0, o_busy}, 32'd1);
      flush_en = 1'b1; flush_tgt = 32'h80;
      step();
      chk("t3_busy2", {31'd0, o_busy}, 32'd1);
      step();
      step();
      refill = 1'b0;
      chk("t3_busy5", {31'd0, o_busy}, 32'd1);
      chk("t3_no_early", {30'd0, o_flush_en, o_branch_en}, 32'd0);
      push(1'b1, 32'h80);
      step();
      chk("t3_busy_clear", {31'd0, o_busy}, 32'd0);
      step();
      chk("t3_epoch", {30'd0, o_epoch}, 32'd0);

      // Four back-to-back flushes, epoch wraps
      for (int i = 0; i < 4; i++) begin
         flush_en = 1'b1; flush_tgt = 32'h1000 * (i + 1); push(1'b1, 32'h1000 * (i + 1));
         step();
      end
      step();
      step();
      chk("t4_epoch_wrap", {30'd0, o_epoch}, 32'd0);

      // Reset while pending
      flush_en = 1'b1; flush_tgt = 32'h77; push(1'b1, 32'h77);
      step();
      refill = 1'b1; flush_en = 1'b1; flush_tgt = 32'h99;
      step();
      chk("t5_busy", {31'd0, o_busy}, 32'd1);
      chk("t5_epoch_pre", {30'd0, o_epoch}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", {31'd0, o_busy}, 32'd0);
      chk("t5_rst_target", o_target, 32'h0);
      chk("t5_rst_epoch", {30'd0, o_epoch}, 32'd0);
      chk("t5_rst_en", {30'd0, o_flush_en, o_branch_en}, 32'd0);
      step();
      refill = 1'b0;
      rst_n = 1'b1;
      exp_ep = 2'd0;
      repeat (6) step();
      chk("t5_post_busy", {31'd0, o_busy}, 32'd0);
      chk("t5_post_epoch", {30'd0, o_epoch}, 32'd0);
      chk("sb_drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
